// File: rtl/fsm_5state.sv
// Purpose: five-state push-button combination lock (program / enter / open / lockout).
// Latency: one clk from an accepted press to count, LED and display updates; Z follows state with no extra delay.
// Backpressure: none; presses are ignored while open or locked out, or once all digits are in.
//
// Ports:
//   clk, reset    : system clock; synchronous active-low reset
//   key[3:0]      : active-low push-buttons, key[i]=0 means button i pressed
//   passkey       : 1 = program a new code, 0 = enter a code
//   Z             : lock open
//   Led[3:0]      : digit-progress thermometer
//   Hex0..Hex5    : active-low 7-segment displays {g,f,e,d,c,b,a}
//                   Hex0 last digit, Hex3 count, Hex2:Hex1 seconds left, Hex4 blank, Hex5 state
module fsm_5state #(
    parameter int nkeys                  = 4,
    parameter int timer1                 = 10,
    parameter int timer2                 = 5,
    parameter int required_clk_frequency = 1,
    parameter int clk_frequency          = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key,
    input  logic       passkey,
    output logic       Z,
    output logic [3:0] Led,
    output logic [6:0] Hex0,
    output logic [6:0] Hex1,
    output logic [6:0] Hex2,
    output logic [6:0] Hex3,
    output logic [6:0] Hex4,
    output logic [6:0] Hex5
);

    localparam int DIV = clk_frequency / required_clk_frequency;
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW  = 4;
    localparam logic [6:0] BLANK = 7'b1111111;

    // Encodings double as the digit shown on Hex5.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PROG  = 3'd1,
        S_ENTER = 3'd2,
        S_OPEN  = 3'd3,
        S_ERROR = 3'd4
    } state_t;

    state_t          state_q, state_nxt;
    logic [3:0]      prev_key_q;
    logic [CW-1:0]   cnt_q;
    logic            mis_q;
    logic [1:0]      last_dig_q;
    logic            last_vld_q;
    logic [6:0]      secs_q;
    logic [PW-1:0]   presc_q;
    logic            z_q;
    logic [1:0]      code_q   [nkeys];
    logic [1:0]      shadow_q [nkeys];

    logic            press;
    logic [1:0]      press_dig;
    logic [1:0]      code_dig;
    logic            accept;
    logic            commit;
    logic            timing;
    logic            tick;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = BLANK;
        endcase
    endfunction

    // A press is a single button going down out of an all-released cycle;
    // held keys and chords never qualify.
    always_comb begin
        press     = 1'b0;
        press_dig = 2'd0;
        if (prev_key_q == 4'b1111) begin
            case (key)
                4'b1110: begin press = 1'b1; press_dig = 2'd0; end
                4'b1101: begin press = 1'b1; press_dig = 2'd1; end
                4'b1011: begin press = 1'b1; press_dig = 2'd2; end
                4'b0111: begin press = 1'b1; press_dig = 2'd3; end
                default: ;
            endcase
        end
    end

    // Stored digit at the current position (count is 0 while idle).
    always_comb begin
        code_dig = code_q[0];
        for (int i = 0; i < nkeys; i++) begin
            if (cnt_q == CW'(i)) code_dig = code_q[i];
        end
    end

    assign timing = (state_q == S_OPEN) || (state_q == S_ERROR);
    assign tick   = (presc_q == PW'(DIV - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= S_IDLE;
        else        state_q <= state_nxt;
    end

    // Next state. Completion is checked before passkey and presses, so the
    // full count is visible on the LEDs for one cycle before leaving.
    always_comb begin
        state_nxt = state_q;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (passkey) begin
                    state_nxt = S_PROG;
                end else if (press) begin
                    state_nxt = S_ENTER;
                    accept    = 1'b1;
                end
            end
            S_PROG: begin
                if (cnt_q == CW'(nkeys)) begin
                    commit    = 1'b1;
                    state_nxt = S_IDLE;
                end else if (!passkey) begin
                    state_nxt = S_IDLE;
                end else if (press) begin
                    accept = 1'b1;
                end
            end
            S_ENTER: begin
                if (cnt_q == CW'(nkeys)) begin
                    state_nxt = mis_q ? S_ERROR : S_OPEN;
                end else if (passkey) begin
                    state_nxt = S_IDLE;
                end else if (press) begin
                    accept = 1'b1;
                end
            end
            S_OPEN, S_ERROR: begin
                if (tick && secs_q == 7'd1) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: key history, count, code storage, seconds timer.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prev_key_q <= 4'b1111;
            cnt_q      <= '0;
            mis_q      <= 1'b0;
            last_dig_q <= 2'd0;
            last_vld_q <= 1'b0;
            secs_q     <= '0;
            presc_q    <= '0;
            z_q        <= 1'b0;
            for (int i = 0; i < nkeys; i++) begin
                code_q[i]   <= 2'd0;
                shadow_q[i] <= 2'd0;
            end
        end else begin
            prev_key_q <= key;
            z_q        <= (state_nxt == S_OPEN);

            if (state_nxt == S_IDLE)     cnt_q <= '0;
            else if (state_q == S_IDLE)  cnt_q <= {3'b000, accept};
            else if (accept)             cnt_q <= cnt_q + 1'b1;

            if (accept) begin
                last_dig_q <= press_dig;
                last_vld_q <= 1'b1;
            end

            // Mismatch accumulates over an entry; the first digit restarts it.
            if (accept && state_q != S_PROG)
                mis_q <= ((state_q == S_ENTER) && mis_q) || (press_dig != code_dig);

            if (accept && state_q == S_PROG) begin
                for (int i = 0; i < nkeys; i++) begin
                    if (cnt_q == CW'(i)) shadow_q[i] <= press_dig;
                end
            end

            // A new code only replaces the old one once every digit is in.
            if (commit) begin
                for (int i = 0; i < nkeys; i++) code_q[i] <= shadow_q[i];
            end

            if (state_nxt == S_OPEN && state_q != S_OPEN) begin
                secs_q  <= 7'(timer1);
                presc_q <= '0;
            end else if (state_nxt == S_ERROR && state_q != S_ERROR) begin
                secs_q  <= 7'(timer2);
                presc_q <= '0;
            end else if (timing) begin
                if (tick) begin
                    presc_q <= '0;
                    secs_q  <= secs_q - 1'b1;
                end else begin
                    presc_q <= presc_q + 1'b1;
                end
            end
        end
    end

    // Outputs.
    always_comb begin
        Z    = z_q;
        Led  = 4'b0000;
        Hex1 = BLANK;
        Hex2 = BLANK;
        if (state_q == S_PROG || state_q == S_ENTER) begin
            for (int i = 0; i < 4; i++) Led[i] = (cnt_q > CW'(i));
        end
        if (timing) begin
            Hex1 = seg7(4'(secs_q % 7'd10));
            if (secs_q >= 7'd10) Hex2 = seg7(4'(secs_q / 7'd10));
        end
        Hex0 = last_vld_q ? seg7({2'b00, last_dig_q}) : BLANK;
        Hex3 = seg7(cnt_q);
        Hex4 = BLANK;
        Hex5 = seg7({1'b0, state_q});
    end

endmodule

// File: tb/tb_fsm_5state.sv
// Purpose: self-checking bench for fsm_5state against a queue-based behavioural lock model.
// Latency: every output compared one cycle after each clock edge.
// Backpressure: none; stimulus is free-running, directed scenarios then random.
module tb_fsm_5state;

    localparam int NKEYS = 4;
    localparam int T1    = 10;
    localparam int T2    = 5;
    localparam int DIV   = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] key;
    logic       passkey;
    logic       Z;
    logic [3:0] Led;
    logic [6:0] Hex0, Hex1, Hex2, Hex3, Hex4, Hex5;

    fsm_5state #(
        .nkeys(NKEYS), .timer1(T1), .timer2(T2),
        .required_clk_frequency(1), .clk_frequency(4)
    ) dut (
        .clk(clk), .reset(reset), .key(key), .passkey(passkey),
        .Z(Z), .Led(Led),
        .Hex0(Hex0), .Hex1(Hex1), .Hex2(Hex2), .Hex3(Hex3), .Hex4(Hex4), .Hex5(Hex5)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;
    int z_hi     = 0;

    logic [6:0] seg_tab [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                                 7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

    // Model: 0 idle, 1 prog, 2 enter, 3 open, 4 error. Digits typed so far
    // live in a queue; the timer is a plain count of cycles left to dwell.
    int         m_state;
    int         m_q[$];
    int         m_code[NKEYS];
    int         m_left;
    int         m_last;
    logic [3:0] m_prev;

    task automatic model_reset();
        m_state = 0;
        m_q.delete();
        foreach (m_code[i]) m_code[i] = 0;
        m_left = 0;
        m_last = -1;
        m_prev = 4'hF;
    endtask

    task automatic model_step();
        bit         pr;
        int         dig;
        bit         ok;
        logic [3:0] pat;
        if (!reset) begin
            model_reset();
            return;
        end
        pr  = 0;
        dig = 0;
        if (m_prev == 4'hF) begin
            for (int i = 0; i < 4; i++) begin
                pat    = 4'hF;
                pat[i] = 1'b0;
                if (key == pat) begin pr = 1; dig = i; end
            end
        end
        case (m_state)
            0: begin
                if (passkey) begin
                    m_state = 1;
                    m_q.delete();
                end else if (pr) begin
                    m_state = 2;
                    m_q.delete();
                    m_q.push_back(dig);
                    m_last = dig;
                end
            end
            1: begin
                if (m_q.size() == NKEYS) begin
                    for (int i = 0; i < NKEYS; i++) m_code[i] = m_q[i];
                    m_state = 0;
                    m_q.delete();
                end else if (!passkey) begin
                    m_state = 0;
                    m_q.delete();
                end else if (pr) begin
                    m_q.push_back(dig);
                    m_last = dig;
                end
            end
            2: begin
                if (m_q.size() == NKEYS) begin
                    ok = 1;
                    for (int i = 0; i < NKEYS; i++) if (m_q[i] != m_code[i]) ok = 0;
                    m_state = ok ? 3 : 4;
                    m_left  = (ok ? T1 : T2) * DIV;
                end else if (passkey) begin
                    m_state = 0;
                    m_q.delete();
                end else if (pr) begin
                    m_q.push_back(dig);
                    m_last = dig;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_state = 0;
                    m_q.delete();
                end
            end
        endcase
        m_prev = key;
    endtask

    task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int         cnt, secs, c;
        logic [3:0] e_led;
        logic [6:0] e_h1, e_h2;
        cnt   = m_q.size();
        c     = (cnt > 4) ? 4 : cnt;
        e_led = (m_state == 1 || m_state == 2) ? 4'((1 << c) - 1) : 4'b0000;
        e_h1  = 7'h7F;
        e_h2  = 7'h7F;
        if (m_state == 3 || m_state == 4) begin
            secs = (m_left + DIV - 1) / DIV;
            e_h1 = seg_tab[secs % 10];
            if (secs >= 10) e_h2 = seg_tab[secs / 10];
        end
        chk("Z",    {6'b0, Z},   {6'b0, (m_state == 3)});
        chk("Led",  {3'b0, Led}, {3'b0, e_led});
        chk("Hex0", Hex0, (m_last < 0) ? 7'h7F : seg_tab[m_last]);
        chk("Hex1", Hex1, e_h1);
        chk("Hex2", Hex2, e_h2);
        chk("Hex3", Hex3, seg_tab[cnt]);
        chk("Hex4", Hex4, 7'h7F);
        chk("Hex5", Hex5, seg_tab[m_state]);
        if (Z === 1'b1) z_hi++;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // One-cycle press followed by one released cycle.
    task automatic press(input int d);
        logic [3:0] pat;
        pat    = 4'hF;
        pat[d] = 1'b0;
        key    = pat;
        cycle();
        key = 4'hF;
        cycle();
    endtask

    initial begin
        int         r;
        logic [3:0] pat;

        reset   = 1'b0;
        key     = 4'hF;
        passkey = 1'b0;
        run(2);
        reset = 1'b1;
        run(2);

        // Program 0,1,2,3.
        passkey = 1'b1;
        cycle();
        press(0); press(1); press(2); press(3);
        run(2);
        passkey = 1'b0;
        run(3);

        // Correct entry: open for exactly T1*DIV cycles.
        z_hi = 0;
        press(0); press(1); press(2); press(3);
        run(50);
        chk("open_dwell", 7'(z_hi), 7'(T1 * DIV));

        // Wrong entry: lockout, presses ignored, Z never rises.
        z_hi = 0;
        press(0); press(1); press(2); press(2);
        press(1); press(3); press(0);
        run(20);
        chk("error_z", 7'(z_hi), 7'd0);

        // Held key and two-key chord.
        key = 4'b1110;
        run(5);
        key = 4'hF;
        cycle();
        key = 4'b1100;
        run(2);
        key = 4'hF;
        cycle();
        passkey = 1'b1;
        run(2);
        passkey = 1'b0;
        run(2);

        // Abandoned programming keeps the old code.
        passkey = 1'b1;
        cycle();
        press(3); press(3);
        passkey = 1'b0;
        run(2);
        z_hi = 0;
        press(0); press(1); press(2); press(3);
        run(45);
        chk("old_code_open", 7'(z_hi), 7'(T1 * DIV));

        // Reset while open clears the code back to 0000.
        press(0); press(1); press(2); press(3);
        run(10);
        reset = 1'b0;
        cycle();
        reset = 1'b1;
        run(2);
        press(0); press(0); press(0); press(0);
        run(45);

        // Random keys, mode changes and occasional resets.
        for (int n = 0; n < 4000; n++) begin
            reset = ($urandom_range(0, 199) != 0);
            r = $urandom_range(0, 99);
            if (r < 45) begin
                key = 4'hF;
            end else if (r < 85) begin
                pat = 4'hF;
                pat[$urandom_range(0, 3)] = 1'b0;
                key = pat;
            end else begin
                key = 4'($urandom);
            end
            if ($urandom_range(0, 99) < 3) passkey = ~passkey;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
